// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN front-end blocks.
//   wg_state_t      : window_gen frame-sequencing FSM states
//   DEF_DATA_WIDTH  : default pixel width
//   DEF_KERNEL_DIM  : default kernel edge length
//   cnt_width()     : counter width for a counter running 0..n-1
// -----------------------------------------------------------------------------
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } wg_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_KERNEL_DIM = 3;

    // Width of a counter covering 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// Single-row delay line: dout is the sample written DEPTH enables ago.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (write pointer only; RAM not reset)
//   en    : advance the delay line by one sample
//   din   : sample written on en
//   dout  : sample leaving the delay line (valid combinationally)
// -----------------------------------------------------------------------------
module line_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH      = 28,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned      PTR_W    = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    // Read-before-write at the same slot gives exactly DEPTH enables of delay,
    // independent of where the pointer sits relative to column 0.
    assign dout = mem[ptr];

endmodule

// File: rtl/window_gen.sv
// -----------------------------------------------------------------------------
// window_gen
// Sliding KERNEL_DIM x KERNEL_DIM window generator over a raster pixel stream.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   sof        : start of frame, marks pixel (0,0) on a transfer
//   in_valid   : pixel_in valid
//   in_ready   : block accepts a pixel this cycle
//   pixel_in   : raster-order pixel
//   out_stall  : downstream hold request
//   window     : KxK neighbourhood, element r*K+c = row r, column c
//                (index 0 top-left, last index = newest pixel)
//   win_valid  : window holds a new full neighbourhood
//   frame_done : one-cycle pulse after the last window of a frame
// -----------------------------------------------------------------------------
module window_gen
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int unsigned KERNEL_DIM = DEF_KERNEL_DIM,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  out_stall,
    output logic [DATA_WIDTH-1:0] window [KERNEL_DIM*KERNEL_DIM],
    output logic                  win_valid,
    output logic                  frame_done
);

    localparam int unsigned      COL_W     = cnt_width(IMG_WIDTH);
    localparam int unsigned      ROW_W     = cnt_width(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_KLAST = COL_W'(KERNEL_DIM - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_KLAST = ROW_W'(KERNEL_DIM - 1);

    wg_state_t state, state_next;

    logic [COL_W-1:0] col, cur_col, col_next;
    logic [ROW_W-1:0] row, cur_row, row_next;
    logic             accept;
    logic             take;
    logic             win_hit;

    logic [DATA_WIDTH-1:0] lb_out [KERNEL_DIM-1];
    logic [DATA_WIDTH-1:0] col_in [KERNEL_DIM];

    // -------------------------------------------------------------------------
    // Transfer qualification and pixel position
    // -------------------------------------------------------------------------
    assign accept = in_valid && in_ready;
    // Pixels accepted in IDLE without sof are dropped and touch nothing.
    assign take   = accept && (sof || (state != ST_IDLE));

    // sof forces the current pixel to (0,0), which also covers a mid-frame restart.
    assign cur_col = sof ? '0 : col;
    assign cur_row = sof ? '0 : row;

    assign col_next = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
    assign row_next = (cur_col == COL_LAST) ? cur_row + 1'b1 : cur_row;

    // Column guard keeps windows from spanning a row wrap.
    assign win_hit = (cur_row >= ROW_KLAST) && (cur_col >= COL_KLAST);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept && sof) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                in_ready = !out_stall;
                if (accept && (cur_row == ROW_KLAST) && (cur_col == '0)) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                in_ready = !out_stall;
                if (accept) begin
                    if (sof) begin
                        state_next = ST_FILL;
                    end else if ((cur_row == ROW_LAST) && (cur_col == COL_LAST)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Position counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (state == ST_DONE) begin
            col <= '0;
            row <= '0;
        end else if (take) begin
            col <= col_next;
            row <= row_next;
        end
    end

    // -------------------------------------------------------------------------
    // Line-buffer chain: stage i outputs the pixel i+1 rows above pixel_in
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < KERNEL_DIM - 1; i++) begin : g_lb
        logic [DATA_WIDTH-1:0] lb_din;
        if (i == 0) begin : g_head
            assign lb_din = pixel_in;
        end else begin : g_tail
            assign lb_din = lb_out[i-1];
        end
        line_buffer #(
            .DEPTH      (IMG_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (take),
            .din  (lb_din),
            .dout (lb_out[i])
        );
    end

    // Incoming right-hand column, oldest row at the top.
    for (genvar r = 0; r < KERNEL_DIM - 1; r++) begin : g_col
        assign col_in[r] = lb_out[KERNEL_DIM-2-r];
    end
    assign col_in[KERNEL_DIM-1] = pixel_in;

    // -------------------------------------------------------------------------
    // Window register: shift left one column per transfer
    // -------------------------------------------------------------------------
    for (genvar r = 0; r < KERNEL_DIM; r++) begin : g_wrow
        for (genvar c = 0; c < KERNEL_DIM; c++) begin : g_wcell
            logic [DATA_WIDTH-1:0] cell_next;
            if (c == KERNEL_DIM - 1) begin : g_edge
                assign cell_next = col_in[r];
            end else begin : g_shift
                assign cell_next = window[r*KERNEL_DIM+c+1];
            end
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    window[r*KERNEL_DIM+c] <= '0;
                end else if (take) begin
                    window[r*KERNEL_DIM+c] <= cell_next;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid <= 1'b0;
        end else if (take) begin
            win_valid <= win_hit;
        end else if (!out_stall) begin
            win_valid <= 1'b0;
        end
    end

    // Registered from DONE so the pulse lands one cycle after the last window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == ST_DONE);
        end
    end

endmodule
